dcache_controller: RTL and testbench
====================================

# dcache_controller

Direct-mapped, write-back, write-allocate data cache between the pipeline's MEM stage (EXMEM address, write-data and MemRead/MemWrite outputs) and the off-chip data memory. Hits complete in the MEM cycle with no stall. A miss freezes the pipeline through `cpu_stall_o` while a 3-state FSM writes back the dirty victim if needed, then refills the line. Read data returns to MEMWB as `ReadData_i`.

## Interface
- `NUM_LINES`, default 16: number of cache lines; must be a power of 2, at least 2.
- `LINE_BITS`, fixed at 256: line size is 32 bytes, 8 words. Offset = addr[4:0], word select = addr[4:2].
- `clk_i` in 1: clock; all state updates on the rising edge.
- `rst_i` in 1: reset. Synchronous and active-high.
- `cpu_addr_i` in 32: byte address from EXMEM ALUdata; word-aligned.
- `cpu_data_i` in 32: store data from EXMEM MemWdata.
- `cpu_MemRead_i` in 1: load request.
- `cpu_MemWrite_i` in 1: store request.
- `cpu_data_o` out 32: load data; valid in the cycle the hit is served.
- `cpu_stall_o` out 1: freeze PC, IFID, IDEX, EXMEM; insert bubble into MEMWB.
- `mem_addr_o` out 32: line-aligned memory address; low 5 bits are 0.
- `mem_data_o` out 256: writeback line.
- `mem_enable_o` out 1: memory request, held until ack.
- `mem_write_o` out 1: 1 = writeback, 0 = refill read.
- `mem_data_i` in 256: refill line; valid with `mem_ack_i`.
- `mem_ack_i` in 1: one-cycle completion pulse from memory.
- `hit_count_o` out 32: statistics (see Configuration).
- `miss_count_o` out 32: statistics (see Configuration).

## Operation
- Address split: tag = addr[31:5+IDX], index = addr[5+IDX-1:5], with IDX = log2(NUM_LINES).
- Per-line state: valid, dirty, tag, 256-bit data.
- Request = `cpu_MemRead_i | cpu_MemWrite_i`. If both are high, the access is treated as a write.
- Hit = valid[index] & (tag[index] == addr tag).

FSM states: IDLE, WRITEBACK, ALLOCATE.
- **IDLE, no request:** `cpu_stall_o`=0, memory outputs idle.
- **IDLE, hit:** `cpu_stall_o`=0.
  - Read: `cpu_data_o` = word[addr[4:2]] (combinational).
  - Write: the word is updated at the clock edge and dirty is set.
- **IDLE, miss:** `cpu_stall_o`=1 in the same cycle.
  - Next state is WRITEBACK if the victim is valid & dirty, else ALLOCATE.
  - Line data is not modified.
- **WRITEBACK:** `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, index, 5'b0}, `mem_data_o`=victim line.
  - Hold until `mem_ack_i`, then go to ALLOCATE.
- **ALLOCATE:** `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={req tag, index, 5'b0}.
  - On `mem_ack_i`: write `mem_data_i` into the line, set tag, valid=1, dirty=0, go to IDLE.
- After the refill, the stalled request is re-evaluated in IDLE and hits. A store then merges its word and sets dirty.
- `cpu_stall_o`=1 throughout WRITEBACK and ALLOCATE, and in IDLE on a miss.
- Request inputs must stay stable while stalled. This is guaranteed because EXMEM is frozen.
- `mem_ack_i` arriving in IDLE is ignored.

## Timing
- **Reset values:** state=IDLE; all valid=0, dirty=0; `cpu_stall_o`=0, `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `cpu_data_o`=0, counters=0.
- **Reset mid-operation:** in-flight writeback or refill is abandoned; no line is updated; dirty data is lost.
- **Hit latency:** 0 stall cycles.
- **Clean-miss stall:** 1 (IDLE detect) + L_refill + 1 (re-lookup hit) cycles, where L = cycles from `mem_enable_o` to `mem_ack_i`, inclusive.
- **Dirty-miss stall:** adds L_wb.
- `mem_enable_o` deasserts in the cycle after ack when the next state is IDLE. From WRITEBACK it stays high, with `mem_write_o` falling to 0 and the address changing in the next cycle.
- `mem_addr_o`, `mem_data_o` and `mem_write_o` are registered and stable for the whole request.

## Configuration
- **`DCACHE_STATS_EN` defined:**
  - `hit_count_o` increments once per IDLE cycle with request & hit, excluding the re-lookup after a refill.
  - `miss_count_o` increments once per IDLE miss detection.
  - Both counters wrap at 2^32 and are cleared by reset.
- **Not defined:** no counter flops; both ports are tied to 32'd0.

## Test plan
- **Cold read miss:** after reset, read 0x0000_0040 with L=10.
  - Expect stall=1 for 12 cycles and `mem_addr_o`=0x40, write=0.
  - `cpu_data_o` must equal refill word 0, then stall=0.
- **Write hit then dirty eviction:**
  - Write 0xDEADBEEF to 0x44 (hit after the previous refill): no stall.
  - Read 0x0000_0240 (same index, NUM_LINES=16).
  - Expect a WRITEBACK to 0x40 whose `mem_data_o` word1=0xDEADBEEF, then ALLOCATE from 0x240.
- **Clean eviction:** read 0x440 after a clean line at the same index. Expect no WRITEBACK; only a refill read to 0x440.
- **Read+write asserted together:** MemRead=MemWrite=1 on a hit at 0x48 with data 0x12345678. Treated as a write: dirty set, and a later read returns 0x12345678.
- **Reset mid-refill:** assert `rst_i` 3 cycles into ALLOCATE.
  - Next cycle: stall=0, `mem_enable_o`=0.
  - A late `mem_ack_i` is ignored; re-reading that address misses again.
- **Stats (`DCACHE_STATS_EN`):** sequence miss, hit, hit, dirty miss. Expect `hit_count_o`=2 and `miss_count_o`=2. With the macro undefined, both read 0.

Source files
------------

// File: rtl/dcache_controller.sv
// Direct-mapped, write-back, write-allocate data cache with an IDLE/WRITEBACK/ALLOCATE miss FSM.
// Optional hit/miss statistics counters are built only when DCACHE_STATS_EN is defined.
module dcache_controller #(
    parameter int NUM_LINES = 16,
    parameter int LINE_BITS = 256
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [31:0]          cpu_addr_i,
    input  logic [31:0]          cpu_data_i,
    input  logic                 cpu_MemRead_i,
    input  logic                 cpu_MemWrite_i,
    output logic [31:0]          cpu_data_o,
    output logic                 cpu_stall_o,
    output logic [31:0]          mem_addr_o,
    output logic [LINE_BITS-1:0] mem_data_o,
    output logic                 mem_enable_o,
    output logic                 mem_write_o,
    input  logic [LINE_BITS-1:0] mem_data_i,
    input  logic                 mem_ack_i,
    output logic [31:0]          hit_count_o,
    output logic [31:0]          miss_count_o
);
    localparam int IDX   = $clog2(NUM_LINES);
    localparam int TAG_W = 27 - IDX;

    typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

    state_t               state_q, state_d;
    logic [NUM_LINES-1:0] valid_q, dirty_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_BITS-1:0] data_q [NUM_LINES];

    logic                 mem_enable_q, mem_enable_d;
    logic                 mem_write_q, mem_write_d;
    logic [31:0]          mem_addr_q, mem_addr_d;
    logic [LINE_BITS-1:0] mem_data_q, mem_data_d;
    logic                 settle_q, settle_d;
    logic                 relook_q, relook_d;

    logic [IDX-1:0]   idx;
    logic [TAG_W-1:0] req_tag;
    logic [2:0]       wsel;
    logic             req, hit, serve, fill, miss_det, stall;
    logic             unused_addr_lsb;

    assign idx             = cpu_addr_i[5+IDX-1:5];
    assign req_tag         = cpu_addr_i[31:5+IDX];
    assign wsel            = cpu_addr_i[4:2];
    assign req             = cpu_MemRead_i | cpu_MemWrite_i;
    assign hit             = valid_q[idx] & (tag_q[idx] == req_tag);
    assign unused_addr_lsb = ^cpu_addr_i[1:0];

    // The refill lands at the ack edge; one settle cycle keeps the pipeline frozen,
    // then the re-lookup serves the stalled request without counting as a hit.
    always_comb begin
        state_d      = state_q;
        mem_enable_d = mem_enable_q;
        mem_write_d  = mem_write_q;
        mem_addr_d   = mem_addr_q;
        mem_data_d   = mem_data_q;
        settle_d     = 1'b0;
        relook_d     = settle_q;
        stall        = 1'b0;
        serve        = 1'b0;
        fill         = 1'b0;
        miss_det     = 1'b0;
        case (state_q)
            IDLE: begin
                if (settle_q) begin
                    stall = 1'b1;
                end else if (req && hit) begin
                    serve = 1'b1;
                end else if (req) begin
                    stall        = 1'b1;
                    miss_det     = 1'b1;
                    mem_enable_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        mem_write_d = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, 5'b0};
                        mem_data_d  = data_q[idx];
                        state_d     = WRITEBACK;
                    end else begin
                        mem_write_d = 1'b0;
                        mem_addr_d  = {req_tag, idx, 5'b0};
                        state_d     = ALLOCATE;
                    end
                end
            end
            WRITEBACK: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    mem_write_d = 1'b0;
                    mem_addr_d  = {req_tag, idx, 5'b0};
                    state_d     = ALLOCATE;
                end
            end
            ALLOCATE: begin
                stall = 1'b1;
                if (mem_ack_i) begin
                    fill         = 1'b1;
                    mem_enable_d = 1'b0;
                    settle_d     = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            mem_enable_q <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_data_q   <= '0;
            settle_q     <= 1'b0;
            relook_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_enable_q <= mem_enable_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_data_q   <= mem_data_d;
            settle_q     <= settle_d;
            relook_q     <= relook_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else if (fill) begin
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
            tag_q[idx]   <= req_tag;
            data_q[idx]  <= mem_data_i;
        end else if (serve && cpu_MemWrite_i) begin
            dirty_q[idx]              <= 1'b1;
            data_q[idx][wsel*32 +: 32] <= cpu_data_i;
        end
    end

    assign cpu_stall_o  = stall;
    assign cpu_data_o   = (serve && !cpu_MemWrite_i) ? data_q[idx][wsel*32 +: 32] : 32'd0;
    assign mem_enable_o = mem_enable_q;
    assign mem_write_o  = mem_write_q;
    assign mem_addr_o   = mem_addr_q;
    assign mem_data_o   = mem_data_q;

`ifdef DCACHE_STATS_EN
    logic [31:0] hit_cnt_q, miss_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (serve && !relook_q) hit_cnt_q <= hit_cnt_q + 32'd1;
            if (miss_det)           miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count_o  = hit_cnt_q;
    assign miss_count_o = miss_cnt_q;
`else
    assign hit_count_o  = 32'd0;
    assign miss_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_dcache_controller.sv
// Bench for dcache_controller: directed scenarios then random traffic, checked against
// a behavioural cache/memory model kept in the bench.
module tb_dcache_controller;
    localparam int NL = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  cpu_addr, cpu_wdata, cpu_rdata;
    logic         cpu_rd, cpu_wr, stall;
    logic [31:0]  mem_addr;
    logic [255:0] mem_wdata, mem_rdata;
    logic         mem_en, mem_we, mem_ack;
    logic [31:0]  hit_cnt, miss_cnt;

    dcache_controller #(.NUM_LINES(NL)) dut (
        .clk_i(clk), .rst_i(rst),
        .cpu_addr_i(cpu_addr), .cpu_data_i(cpu_wdata),
        .cpu_MemRead_i(cpu_rd), .cpu_MemWrite_i(cpu_wr),
        .cpu_data_o(cpu_rdata), .cpu_stall_o(stall),
        .mem_addr_o(mem_addr), .mem_data_o(mem_wdata),
        .mem_enable_o(mem_en), .mem_write_o(mem_we),
        .mem_data_i(mem_rdata), .mem_ack_i(mem_ack),
        .hit_count_o(hit_cnt), .miss_count_o(miss_cnt)
    );

    always #5 clk = ~clk;

    int ncmp = 0;
    int nfail = 0;

    // reference model: cache contents and backing memory
    bit           m_valid [NL];
    bit           m_dirty [NL];
    logic [22:0]  m_tag   [NL];
    logic [255:0] m_data  [NL];
    logic [255:0] mem [logic [31:0]];
    logic [31:0]  s_hit, s_miss;
    logic [31:0]  last_wb_addr, last_rf_addr;
    logic [255:0] last_wb_data;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] mem_rd(input logic [31:0] la);
        logic [255:0] l;
        if (mem.exists(la)) return mem[la];
        for (int k = 0; k < 8; k++) l[k*32 +: 32] = la * 32'h9E3779B1 + 32'(k);
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NL; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        s_hit  = 32'd0;
        s_miss = 32'd0;
    endtask

    task automatic chk_stats(input string tag);
        logic [31:0] eh, em;
`ifdef DCACHE_STATS_EN
        eh = s_hit;
        em = s_miss;
`else
        eh = 32'd0;
        em = 32'd0;
`endif
        chk({tag, "_hits"}, 256'(hit_cnt), 256'(eh));
        chk({tag, "_misses"}, 256'(miss_cnt), 256'(em));
    endtask

    // One CPU access starting at a negedge; returns at a negedge with requests dropped.
    task automatic access(input logic [31:0] a, input bit rd, input bit wr,
                          input logic [31:0] wd, input int lwb, input int lrf);
        logic [3:0]  idx;
        logic [22:0] tag;
        logic [2:0]  wsel;
        logic [31:0] line_addr, victim_addr;
        bit          hit, dirty_victim, done, wb_seen, rf_seen;
        int          exp_stall, stalls, n;
        idx  = a[8:5];
        tag  = a[31:9];
        wsel = a[4:2];
        line_addr    = {a[31:5], 5'b0};
        victim_addr  = {m_tag[idx], idx, 5'b0};
        hit          = m_valid[idx] && (m_tag[idx] == tag);
        dirty_victim = !hit && m_valid[idx] && m_dirty[idx];
        exp_stall    = hit ? 0 : 1 + (dirty_victim ? lwb : 0) + lrf + 1;
        cpu_addr = a; cpu_rd = rd; cpu_wr = wr; cpu_wdata = wd;
        stalls = 0; n = 0; done = 0; wb_seen = 0; rf_seen = 0;
        for (int c = 0; c < 300 && !done; c++) begin
            mem_ack = 1'b0;
            #1;
            if (!stall) begin
                done = 1;
            end else begin
                stalls++;
                if (mem_en) begin
                    n++;
                    if (mem_we) begin
                        if (!wb_seen) begin
                            chk("wb_addr", 256'(mem_addr), 256'(victim_addr));
                            chk("wb_data", mem_wdata, m_data[idx]);
                            last_wb_addr = mem_addr;
                            last_wb_data = mem_wdata;
                            wb_seen = 1;
                        end
                        if (n >= lwb) begin mem_ack = 1'b1; n = 0; end
                    end else begin
                        if (!rf_seen) begin
                            chk("rf_addr", 256'(mem_addr), 256'(line_addr));
                            last_rf_addr = mem_addr;
                            rf_seen = 1;
                        end
                        if (n >= lrf) begin
                            mem_ack = 1'b1;
                            mem_rdata = mem_rd(line_addr);
                            n = 0;
                        end
                    end
                end
                @(negedge clk);
            end
        end
        chk("served", 256'(done), 256'(1));
        chk("stall_cycles", 256'(stalls), 256'(exp_stall));
        chk("wb_happened", 256'(wb_seen), 256'(dirty_victim));
        chk("refill_happened", 256'(rf_seen), 256'(!hit));
        if (hit) s_hit = s_hit + 32'd1;
        else     s_miss = s_miss + 32'd1;
        if (!hit) begin
            if (dirty_victim) mem[victim_addr] = m_data[idx];
            m_data[idx]  = mem_rd(line_addr);
            m_valid[idx] = 1'b1;
            m_dirty[idx] = 1'b0;
            m_tag[idx]   = tag;
        end
        if (done) chk("en_low_on_serve", 256'(mem_en), 256'(0));
        if (wr) begin
            m_data[idx][wsel*32 +: 32] = wd;
            m_dirty[idx] = 1'b1;
        end else if (done) begin
            chk("read_data", 256'(cpu_rdata), 256'(m_data[idx][wsel*32 +: 32]));
        end
        @(negedge clk);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
    endtask

    task automatic idle_cycle(input bit pulse);
        cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_ack = pulse;
        mem_rdata = {8{$urandom()}};
        #1;
        chk("idle_stall", 256'(stall), 256'(0));
        chk("idle_en", 256'(mem_en), 256'(0));
        @(negedge clk);
        mem_ack = 1'b0;
    endtask

    initial begin
        logic [31:0] a, eh, em;
        int          n;
        rst = 1'b1; cpu_addr = '0; cpu_wdata = '0; cpu_rd = 1'b0; cpu_wr = 1'b0;
        mem_rdata = '0; mem_ack = 1'b0;
        last_wb_addr = '0; last_rf_addr = '0; last_wb_data = '0;
        for (int i = 0; i < NL; i++) begin m_tag[i] = '0; m_data[i] = '0; end
        model_reset();
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_stall", 256'(stall), 256'(0));
        chk("rst_en", 256'(mem_en), 256'(0));
        chk("rst_we", 256'(mem_we), 256'(0));
        chk("rst_addr", 256'(mem_addr), 256'(0));
        chk("rst_mdata", mem_wdata, 256'(0));
        chk("rst_cpu_data", 256'(cpu_rdata), 256'(0));
        chk("rst_hit_cnt", 256'(hit_cnt), 256'(0));
        chk("rst_miss_cnt", 256'(miss_cnt), 256'(0));
        @(negedge clk);
        rst = 1'b0;

        // cold read miss, L=10: 12 stall cycles, refill from 0x40
        access(32'h40, 1, 0, 32'h0, 1, 10);
        chk("cold_rf_addr", 256'(last_rf_addr), 256'(32'h40));

        // write hit, then read+write together treated as a write
        access(32'h44, 0, 1, 32'hDEADBEEF, 1, 1);
        access(32'h48, 1, 1, 32'h12345678, 1, 1);
        access(32'h48, 1, 0, 32'h0, 1, 1);

        // dirty eviction to 0x40, then refill from 0x240
        access(32'h240, 1, 0, 32'h0, 4, 5);
        chk("evict_wb_addr", 256'(last_wb_addr), 256'(32'h40));
        chk("evict_wb_word1", 256'(last_wb_data[63:32]), 256'(32'hDEADBEEF));
        chk("evict_wb_word2", 256'(last_wb_data[95:64]), 256'(32'h12345678));
        chk("evict_rf_addr", 256'(last_rf_addr), 256'(32'h240));

        // clean eviction: refill only
        access(32'h440, 1, 0, 32'h0, 3, 2);
        chk("clean_rf_addr", 256'(last_rf_addr), 256'(32'h440));
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // reset three cycles into a refill
        cpu_addr = 32'h80; cpu_rd = 1'b1; cpu_wr = 1'b0;
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            #1;
            if (mem_en && !mem_we) n++;
            if (n < 3) @(negedge clk);
        end
        chk("reached_alloc", 256'(n), 256'(3));
        rst = 1'b1; cpu_rd = 1'b0;
        @(negedge clk);
        #1;
        chk("midrst_stall", 256'(stall), 256'(0));
        chk("midrst_en", 256'(mem_en), 256'(0));
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        idle_cycle(1'b1);
        idle_cycle(1'b0);

        // stats: miss, hit, hit, dirty miss
        access(32'h80, 1, 0, 32'h0, 1, 3);
        access(32'h84, 0, 1, 32'hCAFE0001, 1, 1);
        access(32'h80, 1, 0, 32'h0, 1, 1);
        access(32'h280, 1, 0, 32'h0, 2, 2);
`ifdef DCACHE_STATS_EN
        eh = 32'd2; em = 32'd2;
`else
        eh = 32'd0; em = 32'd0;
`endif
        chk("stats_hit", 256'(hit_cnt), 256'(eh));
        chk("stats_miss", 256'(miss_cnt), 256'(em));
        chk_stats("stats_model");

        // random traffic over a few tags per index
        for (int i = 0; i < 60; i++) begin
            int op;
            a  = {21'd0, 2'($urandom_range(0, 3)), 4'($urandom_range(0, NL-1)),
                  3'($urandom_range(0, 7)), 2'b00};
            op = $urandom_range(0, 2);
            access(a, op != 1, op != 0, $urandom(), $urandom_range(1, 4), $urandom_range(1, 4));
            if ($urandom_range(0, 3) == 0) idle_cycle(1'($urandom_range(0, 1)));
        end
        chk_stats("rand_stats");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule
